// File: rtl/ysyx_23060203_inst_mem.sv
// Instruction-memory responder for the core's fetch port: valid/ready request/response with a
// fixed, parameterised latency, backed by a word array loaded through a side write port.
module ysyx_23060203_inst_mem #(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic [31:0] fetch_q;

    logic [31:0] mem [Depth];

    // Offsets below BASE_ADDR wrap to huge values and fail the range test.
    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] == 2'b00) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[DEPTH_LOG2+1:2];
    endfunction

    logic [31:0] rd_addr;
    logic        rd_ok;
    logic [31:0] rd_word;

    // With LATENCY=1 the array is read on the acceptance edge, so use the live request address.
    always_comb begin
        rd_addr = (state == StIdle) ? req_addr : addr_q;
        rd_ok   = addr_ok(rd_addr);
        rd_word = mem[addr_idx(rd_addr)];
    end

    assign req_ready  = (state == StIdle);
    assign resp_valid = (state == StResp);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign fetch_cnt  = fetch_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= StIdle;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
            fetch_q     <= 32'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (LATENCY <= 1) begin
                            state       <= StResp;
                            resp_data_q <= rd_ok ? rd_word : 32'd0;
                            resp_err_q  <= ~rd_ok;
                        end else begin
                            state <= StWait;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt <= 4'd1) begin
                        state       <= StResp;
                        resp_data_q <= rd_ok ? rd_word : 32'd0;
                        resp_err_q  <= ~rd_ok;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state   <= StIdle;
                        fetch_q <= fetch_q + 32'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Array is never reset; nonblocking write gives read-before-write against the capture above.
    always_ff @(posedge clk) begin
        if (load_en && addr_ok(load_addr)) begin
            mem[addr_idx(load_addr)] <= load_data;
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_inst_mem.sv
// Scoreboard bench for ysyx_23060203_inst_mem: three instances at LATENCY 2, 3 and 1.
module tb_ysyx_23060203_inst_mem;

    localparam int unsigned DL    = 10;
    localparam int unsigned DEPTH = 2 ** DL;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic [2:0]  rstn;
    logic [2:0]  req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
    logic [31:0] req_addr  [3];
    logic [31:0] resp_data [3];
    logic [31:0] load_addr [3];
    logic [31:0] load_data [3];
    logic [31:0] fetch_cnt [3];

    logic [31:0] model   [3][DEPTH];
    logic [31:0] exp_cnt [3];
    logic [32:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ysyx_23060203_inst_mem #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(2)) u_dut0 (
        .clk(clk), .rstn(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_err(resp_err[0]), .load_en(load_en[0]),
        .load_addr(load_addr[0]), .load_data(load_data[0]), .fetch_cnt(fetch_cnt[0])
    );
    ysyx_23060203_inst_mem #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(3)) u_dut1 (
        .clk(clk), .rstn(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_err(resp_err[1]), .load_en(load_en[1]),
        .load_addr(load_addr[1]), .load_data(load_data[1]), .fetch_cnt(fetch_cnt[1])
    );
    ysyx_23060203_inst_mem #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(1)) u_dut2 (
        .clk(clk), .rstn(rstn[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_data(resp_data[2]), .resp_err(resp_err[2]), .load_en(load_en[2]),
        .load_addr(load_addr[2]), .load_data(load_data[2]), .fetch_cnt(fetch_cnt[2])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 3 : 1;
    endfunction

    function automatic logic a_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && (off < 32'(4 * DEPTH));
    endfunction

    function automatic logic [32:0] exp_of(input int d, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!a_ok(a)) return {1'b1, 32'h0};
        return {1'b0, model[d][off[DL+1:2]]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] v);
        logic [31:0] off;
        off = a - BASE;
        if (a_ok(a)) model[d][off[DL+1:2]] = v;
    endtask

    task automatic load(input int d, input logic [31:0] a, input logic [31:0] v);
        load_en[d] = 1'b1;
        load_addr[d] = a;
        load_data[d] = v;
        tick();
        load_en[d] = 1'b0;
        model_write(d, a, v);
    endtask

    task automatic sb_pop(input int d);
        logic [32:0] e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("resp_data", resp_data[d], e[31:0]);
            check_val("resp_err", {31'd0, resp_err[d]}, {31'd0, e[32]});
        end
    endtask

    // Called at a negedge; ld_k > 0 drives a load of ld_v to addr at the k-th edge after acceptance.
    task automatic fetch(input int d, input logic [31:0] a, input int bp, input int ld_k,
                         input logic [31:0] ld_v);
        logic [32:0] e;
        int n;
        int k;
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        resp_ready[d] = (bp == 0);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready[d]) begin
            check_val("accept_timeout", 32'd1, 32'd0);
            req_valid[d] = 1'b0;
            return;
        end
        e = exp_of(d, a);
        if (ld_k >= 1 && ld_k <= lat_of(d) - 2) e = {1'b0, ld_v};
        sb_q.push_back(e);
        tick();
        req_valid[d] = 1'b0;
        k = 1;
        while (!resp_valid[d] && k < 20) begin
            load_en[d]   = (ld_k == k);
            load_addr[d] = a;
            load_data[d] = ld_v;
            tick();
            k++;
        end
        load_en[d] = 1'b0;
        if (ld_k > 0) model_write(d, a, ld_v);
        check_val("latency", k, lat_of(d));
        if (!resp_valid[d]) begin
            check_val("resp_timeout", 32'd1, 32'd0);
            sb_q.delete();
            return;
        end
        for (int i = 0; i < bp; i++) begin
            check_val("bp_data", resp_data[d], e[31:0]);
            check_val("bp_req_ready", {31'd0, req_ready[d]}, 32'd0);
            tick();
        end
        resp_ready[d] = 1'b1;
        sb_pop(d);
        tick();
        resp_ready[d] = 1'b0;
        exp_cnt[d] = exp_cnt[d] + 32'd1;
        check_val("ready_after", {31'd0, req_ready[d]}, 32'd1);
        check_val("fetch_cnt", fetch_cnt[d], exp_cnt[d]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        int last_acc;
        logic prev_acc;
        logic acc;
        logic [31:0] a;

        rstn = 3'b000;
        req_valid = '0;
        resp_ready = '0;
        load_en = '0;
        for (int d = 0; d < 3; d++) begin
            req_addr[d] = BASE;
            load_addr[d] = BASE;
            load_data[d] = '0;
            exp_cnt[d] = '0;
            for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
        end
        tick();
        tick();
        rstn = 3'b111;
        tick();
        for (int d = 0; d < 3; d++) begin
            check_val("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
            check_val("rst_resp_valid", {31'd0, resp_valid[d]}, 32'd0);
            check_val("rst_resp_data", resp_data[d], 32'd0);
            check_val("rst_resp_err", {31'd0, resp_err[d]}, 32'd0);
            check_val("rst_fetch_cnt", fetch_cnt[d], 32'd0);
        end

        // LATENCY=2: basic fetches, backpressure, error addresses, dropped load.
        load(0, 32'h8000_0000, 32'h0000_0413);
        load(0, 32'h8000_0004, 32'h0010_0073);
        fetch(0, 32'h8000_0000, 0, 0, '0);
        fetch(0, 32'h8000_0004, 0, 0, '0);
        check_val("cnt_two", fetch_cnt[0], 32'd2);
        fetch(0, 32'h8000_0004, 5, 0, '0);
        fetch(0, 32'h8000_0002, 0, 0, '0);
        fetch(0, 32'h7FFF_FFFC, 0, 0, '0);
        fetch(0, BASE + 32'(4 * DEPTH), 0, 0, '0);
        load(0, BASE + 32'(4 * DEPTH), 32'hDEAD_BEEF);
        load(0, 32'h8000_0006, 32'hDEAD_BEEF);
        fetch(0, 32'h8000_0000, 0, 0, '0);
        fetch(0, 32'h8000_0004, 0, 0, '0);

        // LATENCY=3: load visibility relative to the RESP-entry edge.
        load(1, 32'h8000_0010, 32'h1111_1111);
        fetch(1, 32'h8000_0010, 0, 1, 32'h2222_2222);
        load(1, 32'h8000_0010, 32'h1111_1111);
        fetch(1, 32'h8000_0010, 0, 2, 32'h2222_2222);
        fetch(1, 32'h8000_0010, 0, 0, '0);

        // Reset during WAIT aborts the fetch and preserves the array.
        req_valid[1] = 1'b1;
        req_addr[1] = 32'h8000_0010;
        tick();
        req_valid[1] = 1'b0;
        rstn[1] = 1'b0;
        #1;
        check_val("arst_req_ready", {31'd0, req_ready[1]}, 32'd1);
        check_val("arst_fetch_cnt", fetch_cnt[1], 32'd0);
        tick();
        tick();
        rstn[1] = 1'b1;
        exp_cnt[1] = '0;
        hits = 0;
        resp_ready[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid[1]) hits++;
            tick();
        end
        resp_ready[1] = 1'b0;
        check_val("abort_no_resp", hits, 32'd0);
        check_val("abort_fetch_cnt", fetch_cnt[1], 32'd0);
        check_val("abort_req_ready", {31'd0, req_ready[1]}, 32'd1);
        fetch(1, 32'h8000_0010, 0, 0, '0);

        // LATENCY=1 back-to-back with req_valid held high.
        for (int i = 0; i < 6; i++) load(2, BASE + 32'(4 * i), 32'h0101_0101 * (i + 3));
        a = BASE;
        req_addr[2] = a;
        req_valid[2] = 1'b1;
        resp_ready[2] = 1'b1;
        prev_acc = 1'b0;
        last_acc = -1;
        for (int c = 0; c < 12; c++) begin
            if (prev_acc) begin
                a = a + 32'd4;
                req_addr[2] = a;
            end
            if (c > 0) check_val("b2b_valid", {31'd0, resp_valid[2]}, {31'd0, prev_acc});
            if (resp_valid[2]) begin
                sb_pop(2);
                exp_cnt[2] = exp_cnt[2] + 32'd1;
            end
            acc = req_ready[2];
            if (acc) begin
                sb_q.push_back(exp_of(2, a));
                if (last_acc >= 0) check_val("b2b_gap", c - last_acc, 32'd2);
                last_acc = c;
            end
            prev_acc = acc;
            tick();
        end
        req_valid[2] = 1'b0;
        resp_ready[2] = 1'b0;
        check_val("sb_empty", sb_q.size(), 32'd0);
        check_val("b2b_cnt", fetch_cnt[2], exp_cnt[2]);

        // fetch_cnt wraps from all-ones to zero.
        force u_dut0.fetch_q = 32'hFFFF_FFFF;
        tick();
        release u_dut0.fetch_q;
        tick();
        check_val("cnt_preload", fetch_cnt[0], 32'hFFFF_FFFF);
        exp_cnt[0] = 32'hFFFF_FFFF;
        fetch(0, 32'h8000_0000, 0, 0, '0);
        check_val("cnt_wrap", fetch_cnt[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_inst_mem.md
# ysyx_23060203_inst_mem

Instruction-memory responder on the far end of the core's fetch port. It serves word fetches over a valid/ready request/response handshake with a configurable fixed latency. It is backed by a word array that the simulation driver loads through a side write port. It replaces the driver-side combinational `inst_mem_addr`/`inst_mem_data` model, so the IFU can be verified against realistic multi-cycle memory.

## Interface
- `DEPTH_LOG2`, default 16: array holds 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`. Legal range 1..15.

- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `req_valid` input 1: fetch request present.
- `req_ready` output 1: responder can accept a request.
- `req_addr` input 32: byte address of the fetch.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: fetcher accepts the response.
- `resp_data` output 32: fetched instruction word.
- `resp_err` output 1: the address was misaligned or out of range.
- `load_en` input 1: driver word write enable.
- `load_addr` input 32: byte address for the driver write.
- `load_data` input 32: word to write.
- `fetch_cnt` output 32: count of completed response handshakes.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: latency countdown.
  - RESP: `resp_valid`=1.
- Transitions:
  - IDLE→WAIT on `req_valid & req_ready` when LATENCY>1. The address is latched and the counter is loaded with LATENCY-1.
  - IDLE→RESP directly when LATENCY=1.
  - WAIT decrements each cycle; WAIT→RESP when the counter reaches 1.
  - RESP→IDLE on `resp_valid & resp_ready`.
- Index = (addr − BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
- The address is valid iff addr[1:0]==0 and (addr − BASE_ADDR) < 4·2^DEPTH_LOG2. Addresses below BASE_ADDR wrap to large values and are therefore invalid.
- `resp_data` and `resp_err` are registered on entry to RESP and held stable for the whole RESP state.
- Invalid address: `resp_err`=1, `resp_data`=0. Valid address: `resp_err`=0, `resp_data`=array[index].
- The array is read on the cycle of entry to RESP, not at acceptance. A load to the fetched word during WAIT is therefore visible.
- Load port: a valid `load_addr` writes `load_data` into the array at the clock edge. Invalid load addresses are silently dropped. The port works in every state and has no handshake.
- Load and response capture to the same word on the same edge: the response returns the old data (read-before-write).
- `fetch_cnt` increments on every response handshake and wraps 2^32−1→0.
- Only one request is outstanding at a time. `req_addr` is ignored outside IDLE.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state=IDLE, counter=0.
  - `req_ready`=1, `resp_valid`=0.
  - `resp_data`=0, `resp_err`=0.
  - `fetch_cnt`=0.
  - Array contents are not reset.
- Reset mid-transaction aborts the fetch; no response is ever produced for it.
- Accept at edge E0 (IDLE with `req_valid`=1). `resp_valid` is high starting LATENCY cycles after E0: for LATENCY=1, the cycle immediately following E0.
- `req_ready` is combinationally equal to (state==IDLE). It does not depend on `req_valid`.
- `resp_valid`/`resp_data`/`resp_err` are held with no change until `resp_ready`=1. Arbitrary backpressure is tolerated.
- After the response handshake edge the block returns to IDLE; `req_ready` is high in the next cycle. A request cannot be accepted in the same cycle as a response handshake.
- Peak throughput: one fetch per LATENCY+1 cycles.
- `resp_ready` outside RESP has no effect.

## Test plan
- Reset, then load 0x0000_0413 at 0x8000_0000 and 0x0010_0073 at 0x8000_0004; fetch both with LATENCY=2, `resp_ready`=1.
  - Response 1: `resp_data`=0x0000_0413, `resp_err`=0, `resp_valid` rising exactly 2 cycles after acceptance.
  - Response 2: `resp_data`=0x0010_0073.
  - `fetch_cnt`=2.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP.
  - Data stays constant and `req_ready`=0 throughout.
  - On release, the handshake happens; `req_ready`=1 on the next cycle.
- Errors:
  - Fetch 0x8000_0002 → `resp_err`=1, `resp_data`=0.
  - Fetch 0x7FFF_FFFC → `resp_err`=1.
  - Fetch BASE_ADDR+4·2^DEPTH_LOG2 → `resp_err`=1.
  - `fetch_cnt` still increments on each of these.
- Load/read ordering, LATENCY=3, fetch 0x8000_0010 holding 0x1111_1111:
  - Load 0x2222_2222 to that word one cycle after acceptance → response 0x2222_2222.
  - Repeat with the load on the RESP-entry edge → response 0x1111_1111.
- Assert `rstn`=0 during WAIT, then release.
  - No `resp_valid`, `fetch_cnt`=0, `req_ready`=1.
  - Array contents are preserved across reset.
- LATENCY=1 back-to-back fetches, `req_valid` held high:
  - `resp_valid` high in the cycle after acceptance.
  - Acceptances occur every 2 cycles.
- Preload `fetch_cnt` to 0xFFFF_FFFF via a hierarchical force, then complete one fetch → `fetch_cnt`=0.
